// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlapping/non-overlapping modes.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               w,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic               busy,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HUNT} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               z_q, z_d;
    logic               busy_q, busy_d;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic               sample;
    logic               cfg_ok;
    logic               match;

    always_comb begin
        cfg_ok   = (len >= LEN_W'(2)) && (len <= LEN_W'(MAX_LEN));
        sample   = en && !load;
        hist_nxt = {hist_q[MAX_LEN-2:0], w};
        fill_inc = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        // Only evaluated once at least len_r bits (including this one) have been seen.
        match = sample && (state_q != S_IDLE) && (fill_inc >= {1'b0, len_q})
                && ((hist_nxt & mask) == (pat_q & mask));

        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        z_d     = 1'b0;

        if (load) begin
            pat_d   = pattern;
            len_d   = len;
            ovl_d   = overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = cfg_ok ? S_FILL : S_IDLE;
        end else if (sample) begin
            hist_d = hist_nxt;
            fill_d = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
            z_d    = match;
            if (state_q == S_FILL && fill_inc == {1'b0, len_q}) begin
                state_d = S_HUNT;
            end
            // Non-overlapping mode demands a full fresh pattern after each hit.
            if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = S_FILL;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
        end
    end

    assign z    = z_q;
    assign busy = busy_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (z_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               w = 1'b0;
    logic               load = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   len = '0;
    logic               overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               z;
    logic               busy;
    logic [CNT_W-1:0]   match_cnt;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .pattern(pattern),
        .len(len), .overlap(overlap), .cnt_clr(cnt_clr), .z(z), .busy(busy),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int z_seen = 0;

    // Reference model: the bits sampled since the last (re)start, plus the loaded config.
    bit                 mq[$];
    logic [MAX_LEN-1:0] m_pat = '0;
    int                 m_len = 0;
    bit                 m_ovl = 0;
    bit                 m_valid = 0;
    bit                 exp_z = 0;
    int                 exp_cnt = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cnt_expect(input int c);
`ifdef SEQ_DET_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pat = '0; m_len = 0; m_ovl = 0; m_valid = 0;
        exp_z = 0; exp_cnt = 0;
    endtask

    task automatic model_edge();
        bit hit;
        exp_z = 0;
        if (load) begin
            m_pat   = pattern;
            m_len   = int'(len);
            m_ovl   = overlap;
            m_valid = (m_len >= 2) && (m_len <= MAX_LEN);
            mq.delete();
        end else if (en) begin
            mq.push_back(w);
            if (mq.size() > MAX_LEN) void'(mq.pop_front());
            if (m_valid && mq.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (mq[mq.size()-1-i] != m_pat[i]) hit = 0;
                if (hit) begin
                    exp_z = 1;
                    if (!m_ovl) mq.delete();
                end
            end
        end
        if (cnt_clr) exp_cnt = 0;
        else if (exp_z && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_eq("z", int'(z), int'(exp_z));
        check_eq("busy", int'(busy), int'(m_valid));
        check_eq("match_cnt", int'(match_cnt), cnt_expect(exp_cnt));
        if (z) z_seen++;
    endtask

    task automatic do_load(input logic [MAX_LEN-1:0] p, input int l, input bit o);
        load = 1; pattern = p; len = LEN_W'(l); overlap = o; en = 1; w = 1;
        tick();
        load = 0;
    endtask

    task automatic send(input bit b);
        en = 1; w = b;
        tick();
    endtask

    task automatic hold(input int n);
        en = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_cnt();
        en = 0; cnt_clr = 1;
        tick();
        cnt_clr = 0;
        z_seen = 0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        check_eq("rst_z", int'(z), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1;

        // Overlapping: 1011 over 1,0,1,1,0,1,1
        clear_cnt();
        do_load(8'b1011, 4, 1'b1);
        send_bits(16'b1011011, 7);
        hold(1);
        check_eq("ovl_zcount", z_seen, 2);
        check_eq("ovl_cnt", int'(match_cnt), cnt_expect(2));

        // Non-overlapping on the same stream
        clear_cnt();
        do_load(8'b1011, 4, 1'b0);
        send_bits(16'b1011011, 7);
        hold(1);
        check_eq("novl_zcount", z_seen, 1);
        check_eq("novl_cnt", int'(match_cnt), cnt_expect(1));

        // Run of ones, both modes
        clear_cnt();
        do_load(8'b111, 3, 1'b1);
        send_bits(16'b11111, 5);
        hold(1);
        check_eq("ones_ovl_zcount", z_seen, 3);
        clear_cnt();
        do_load(8'b111, 3, 1'b0);
        send_bits(16'b11111, 5);
        hold(1);
        check_eq("ones_novl_zcount", z_seen, 1);

        // Enable gaps, then an invalid reload
        clear_cnt();
        do_load(8'b11, 2, 1'b1);
        send(1'b1);
        hold(3);
        check_eq("en_gap_z", z_seen, 0);
        send(1'b1);
        check_eq("en_match_z", int'(z), 1);
        do_load(8'b1, 1, 1'b1);
        check_eq("len1_busy", int'(busy), 0);
        z_seen = 0;
        send_bits(16'b111, 3);
        check_eq("len1_zcount", z_seen, 0);

        // Asynchronous reset mid-stream
        do_load(8'b1011, 4, 1'b1);
        send_bits(16'b101, 3);
        #2;
        rst = 0;
        #1;
        model_reset();
        check_eq("arst_z", int'(z), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_cnt", int'(match_cnt), 0);
        @(negedge clk);
        rst = 1;
        z_seen = 0;
        send(1'b1);
        check_eq("post_rst_zcount", z_seen, 0);

        // Counter saturation and clear-vs-match priority
        clear_cnt();
        do_load(8'b11, 2, 1'b1);
        send_bits(16'b111111, 6);
        check_eq("sat_cnt", int'(match_cnt), cnt_expect(3));
        cnt_clr = 1;
        send(1'b1);
        cnt_clr = 0;
        check_eq("clr_wins_z", int'(z), 1);
        check_eq("clr_wins_cnt", int'(match_cnt), 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            load    = ($urandom_range(0, 99) < 3);
            cnt_clr = ($urandom_range(0, 19) == 0);
            en      = ($urandom_range(0, 3) != 0);
            w       = 1'($urandom);
            if (load) begin
                pattern = MAX_LEN'($urandom);
                len     = ($urandom_range(0, 9) == 0) ? LEN_W'(15) : LEN_W'($urandom_range(0, 9));
                overlap = 1'($urandom);
            end
            tick();
        end
        load = 0; cnt_clr = 0; en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
